// File: rtl/wb_mmio_stage.sv
// Writeback stage with memory-mapped HEX/LED output registers, a retired-instruction
// counter, and a one-way HALT latch released only by reset.
module wb_mmio_stage #(
  parameter int               DBITS      = 32,
  parameter int               REGNOBITS  = 5,
  parameter int               HEX_DIGITS = 6,
  parameter logic [31:0]      HEX_RESET  = 32'h00FEDEAD,
  parameter int               LED_BITS   = 10,
  parameter bit               LED_STICKY = 1'b0,
  parameter int               CNT_BITS   = 32,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hFFFFF000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hFFFFF020,
  parameter logic [DBITS-1:0] ADDR_HALT  = 32'hFFFFF0F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [DBITS-1:0]      memaddr_i,
  input  logic [DBITS-1:0]      regval_i,
  input  logic [DBITS-1:0]      regval2_i,
  input  logic                  wr_mem_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  wr_reg_i,
  input  logic [REGNOBITS-1:0]  wregno_i,
  output logic                  wb_wr_reg_o,
  output logic [REGNOBITS-1:0]  wb_wregno_o,
  output logic [DBITS-1:0]      wb_regval_o,
  output logic [4*HEX_DIGITS-1:0] hex_o,
  output logic [LED_BITS-1:0]   ledr_o,
  output logic [CNT_BITS-1:0]   instret_o,
  output logic                  halted_o
);
  localparam int HEX_BITS = 4*HEX_DIGITS;

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [HEX_BITS-1:0]   r_hex;
  logic [LED_BITS-1:0]   r_ledr;
  logic [CNT_BITS-1:0]   r_instret;

  logic                  w_accept;
  logic [DBITS-1:0]      w_waddr;
  logic                  w_st_hex, w_st_led, w_st_halt;
  logic [31:0]           w_lane_mask, w_lane_data;
  logic [HEX_BITS-1:0]   w_hex_nxt;

  assign w_accept = valid_i && (r_state == S_RUN);
  assign w_waddr  = {memaddr_i[DBITS-1:2], 2'b00};
  assign w_st_hex  = w_accept && wr_mem_i && (w_waddr == ADDR_HEX);
  assign w_st_led  = w_accept && wr_mem_i && (w_waddr == ADDR_LEDR);
  assign w_st_halt = w_accept && wr_mem_i && (w_waddr == ADDR_HALT);

  // Register-file writes bypass all state so DE sees them in the same cycle.
  assign wb_wr_reg_o = w_accept && wr_reg_i;
  assign wb_wregno_o = wregno_i;
  assign wb_regval_o = regval_i;

  // Replicate the store data across lanes; the mask picks which lane lands.
  always_comb begin
    w_lane_mask = 32'hFFFF_FFFF;
    w_lane_data = regval2_i[31:0];
    case (mem_size_i)
      2'b00: begin
        w_lane_mask = 32'h0000_00FF << {memaddr_i[1:0], 3'b000};
        w_lane_data = {4{regval2_i[7:0]}};
      end
      2'b01: begin
        w_lane_mask = memaddr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_lane_data = {2{regval2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane bits above HEX_BITS fall off here.
  assign w_hex_nxt = (r_hex & ~w_lane_mask[HEX_BITS-1:0]) |
                     (w_lane_data[HEX_BITS-1:0] & w_lane_mask[HEX_BITS-1:0]);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN && w_st_halt) w_state_nxt = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_hex     <= HEX_RESET[HEX_BITS-1:0];
      r_ledr    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_instret <= r_instret + CNT_BITS'(1);
      if (w_st_hex) r_hex <= w_hex_nxt;
      if (w_st_led) r_ledr <= LED_STICKY ? (r_ledr | regval2_i[LED_BITS-1:0])
                                         : regval2_i[LED_BITS-1:0];
    end
  end

  assign hex_o     = r_hex;
  assign ledr_o    = r_ledr;
  assign instret_o = r_instret;
  assign halted_o  = (r_state == S_HALTED);
endmodule

// File: doc/wb_mmio_stage.md
WB_MMIO_STAGE -- requirements
Module: wb_mmio_stage

Interface
REQ-001 Parameter DBITS, 32, data/address width.
REQ-002 Parameter REGNOBITS, 5, register-number width.
REQ-003 Parameter HEX_DIGITS, 6, number of 4-bit HEX digits (1..8); HEX_BITS = 4*HEX_DIGITS.
REQ-004 Parameter HEX_RESET, 32'h00FEDEAD, reset image of HEX register (low HEX_BITS used).
REQ-005 Parameter LED_BITS, 10, LED register width (1..DBITS).
REQ-006 Parameter LED_STICKY, 0, 0 = LED write replaces, 1 = LED write ORs into current value.
REQ-007 Parameter CNT_BITS, 32, retire-counter width.
REQ-008 Parameters ADDR_HEX 32'hFFFFF000, ADDR_LEDR 32'hFFFFF020, ADDR_HALT 32'hFFFFF0F0, word-aligned MMIO addresses.
REQ-009 clk  in  1  sole clock, all state on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 valid_i  in  1  MEM latch holds a real instruction this cycle.
REQ-012 memaddr_i  in  DBITS  store/load byte address.
REQ-013 regval_i  in  DBITS  register writeback value.
REQ-014 regval2_i  in  DBITS  store data.
REQ-015 wr_mem_i  in  1  instruction is a store.
REQ-016 mem_size_i  in  2  store size: 00 byte, 01 half, 10/11 word.
REQ-017 wr_reg_i  in  1  instruction writes a register.
REQ-018 wregno_i  in  REGNOBITS  destination register.
REQ-019 wb_wr_reg_o  out  1  register-file write enable to DE.
REQ-020 wb_wregno_o  out  REGNOBITS  register-file write index to DE.
REQ-021 wb_regval_o  out  DBITS  register-file write data to DE.
REQ-022 hex_o  out  HEX_BITS  HEX register; digit k = hex_o[4k+3:4k].
REQ-023 ledr_o  out  LED_BITS  LED register.
REQ-024 instret_o  out  CNT_BITS  retired-instruction count.
REQ-025 halted_o  out  1  block is in HALTED state.

Function
REQ-026 accept = valid_i AND state==RUN; all updates below occur only on accept.
REQ-027 Writeback outputs SHALL be combinational: wb_wr_reg_o = accept AND wr_reg_i; wb_wregno_o = wregno_i; wb_regval_o = regval_i; zero latency.
REQ-028 Register writes to wregno 0 SHALL still be presented; DE discards them.
REQ-029 MMIO match SHALL compare memaddr_i with bits [1:0] cleared against each ADDR_* parameter.
REQ-030 HEX store SHALL update, on the accepting edge, only the lanes selected by size: byte -> byte lane memaddr_i[1:0] from regval2_i[7:0]; half -> half-lane memaddr_i[1] from regval2_i[15:0]; word -> all 32 bits; lane bits at or above HEX_BITS SHALL be dropped.
REQ-031 LED store SHALL write ledr <= regval2_i[LED_BITS-1:0] (LED_STICKY=0) or ledr <= ledr | regval2_i[LED_BITS-1:0] (LED_STICKY=1), independent of mem_size_i.
REQ-032 MMIO register outputs SHALL change the cycle after the accepting edge; loads and non-matching stores SHALL leave them unchanged.
REQ-033 instret SHALL increment by 1 per accept, wrapping from 2^CNT_BITS-1 to 0.
REQ-034 State machine RUN/HALTED: RUN -> HALTED on accept AND wr_mem_i AND match ADDR_HALT; HALTED -> RUN only by reset.
REQ-035 The halting store SHALL itself retire (counted) and may write a register in the same cycle.
REQ-036 In HALTED, valid_i SHALL be ignored: wb_wr_reg_o=0, hex/ledr/instret frozen, halted_o=1.
REQ-037 Simultaneous reset and accept: reset SHALL win; no update from that instruction.

Reset
REQ-038 On a clk edge with reset=1: state=RUN, hex_o=HEX_RESET[HEX_BITS-1:0], ledr_o=0, instret_o=0, halted_o=0; asserting reset mid-run or in HALTED SHALL behave identically.
REQ-039 During reset, wb_wr_reg_o SHALL follow REQ-027 (state forced to RUN next edge, combinational path unaffected).

Verification
REQ-040 Reset, then word store ADDR_HEX data 32'h00123456 -> hex_o 24'h123456 next cycle, instret_o=1.
REQ-041 Byte store ADDR_HEX+2 data 8'hAB after REQ-040 -> hex_o 24'hAB3456; half store ADDR_HEX+2 data 16'hBEEF with HEX_DIGITS=6 -> hex_o 24'hEF3456.
REQ-042 LED_STICKY=1: stores 10'h001 then 10'h200 to ADDR_LEDR -> ledr_o 10'h201; LED_STICKY=0 same stimulus -> 10'h200.
REQ-043 valid_i=1, wr_reg_i=1, wregno 7, regval 32'hDEADBEEF -> same cycle wb_wr_reg_o=1, wb_wregno_o=7, wb_regval_o=32'hDEADBEEF; valid_i=0 -> wb_wr_reg_o=0, instret unchanged.
REQ-044 Store to ADDR_HALT then 3 valid register writes -> halted_o=1 next cycle, instret_o stays 1, wb_wr_reg_o=0 for the 3; reset -> halted_o=0, instret_o=0.
REQ-045 CNT_BITS=4, 17 consecutive accepts -> instret_o=1 (wrap).
